// File: rtl/xor_gate_sequencer_if.sv
// Bundles the start request, the gate under control and the result LEDs
// into one port group for the xor_gate_sequencer.
interface xor_gate_sequencer_if;
    logic       start;
    logic       dut_y;
    logic       dut_a;
    logic       dut_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] result;
    logic [1:0] fail_idx;

    // Board/bench side: owns the start switch and the gate output
    modport master (
        output start,
        output dut_y,
        input  dut_a,
        input  dut_b,
        input  busy,
        input  done,
        input  pass,
        input  result,
        input  fail_idx
    );

    // Sequencer side
    modport slave (
        input  start,
        input  dut_y,
        output dut_a,
        output dut_b,
        output busy,
        output done,
        output pass,
        output result,
        output fail_idx
    );
endinterface

// File: rtl/xor_gate_sequencer.sv
// Steps a 2-input XOR gate through 00,01,10,11 with a programmable dwell and
// checks each output. Optional macro SEQ_STOP_ON_FAIL_EN ends a run at the first mismatch.
module xor_gate_sequencer #(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xor_gate_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(STEP_CYCLES - 1);

    function automatic logic expected_y(input logic [1:0] vec);
        return vec[1] ^ vec[0];
    endfunction

    state_t     state_r;
    logic [1:0] idx_r;
    logic [7:0] cnt_r;
    logic       start_q_r;
    logic [3:0] result_r;
    logic [1:0] fail_idx_r;
    logic       fail_seen_r;
    logic       dut_a_r;
    logic       dut_b_r;
    logic       busy_r;
    logic       done_r;

    logic       start_rise_s;
    logic       last_cnt_s;
    logic       sample_ok_s;
    logic       finish_s;
    logic [1:0] idx_next_s;

    // Edge detect, dwell-end detect and end-of-run decision for the current cycle
    always_comb begin
        start_rise_s = bus.start & ~start_q_r;
        last_cnt_s   = (cnt_r == LAST_CNT);
        sample_ok_s  = (bus.dut_y == expected_y(idx_r));
        idx_next_s   = idx_r + 2'd1;
`ifdef SEQ_STOP_ON_FAIL_EN
        finish_s     = (idx_r == 2'd3) | ~sample_ok_s;
`else
        finish_s     = (idx_r == 2'd3);
`endif
    end

    // Start switch history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q_r <= 1'b0;
        end else begin
            start_q_r <= bus.start;
        end
    end

    // Sequencer FSM with registered gate drives and LED outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 2'd0;
            cnt_r       <= 8'd0;
            result_r    <= 4'd0;
            fail_idx_r  <= 2'd0;
            fail_seen_r <= 1'b0;
            dut_a_r     <= 1'b0;
            dut_b_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_rise_s) begin
                        state_r     <= ST_APPLY;
                        idx_r       <= 2'd0;
                        cnt_r       <= 8'd0;
                        result_r    <= 4'd0;
                        fail_idx_r  <= 2'd0;
                        fail_seen_r <= 1'b0;
                        dut_a_r     <= 1'b0;
                        dut_b_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (!last_cnt_s) begin
                        cnt_r <= cnt_r + 8'd1;
                    end else begin
                        result_r[idx_r] <= sample_ok_s;
                        // fail_idx latches only the first mismatch of the run
                        if (!sample_ok_s && !fail_seen_r) begin
                            fail_seen_r <= 1'b1;
                            fail_idx_r  <= idx_r;
                        end
                        cnt_r <= 8'd0;
                        if (finish_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            dut_a_r <= 1'b0;
                            dut_b_r <= 1'b0;
                        end else begin
                            idx_r   <= idx_next_s;
                            dut_a_r <= idx_next_s[1];
                            dut_b_r <= idx_next_s[0];
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= 2'd0;
                    cnt_r       <= 8'd0;
                    result_r    <= 4'd0;
                    fail_idx_r  <= 2'd0;
                    fail_seen_r <= 1'b0;
                    dut_a_r     <= 1'b0;
                    dut_b_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_a    = dut_a_r;
    assign bus.dut_b    = dut_b_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = done_r & (&result_r);
    assign bus.result   = result_r;
    assign bus.fail_idx = fail_idx_r;

endmodule

// File: tb/tb_xor_gate_sequencer.sv
// Drives xor_gate_sequencer against a table-defined gate and checks every cycle
// of each run against a truth-table reference model.
module tb_xor_gate_sequencer;

    localparam int S = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] gate_tt;   // gate_tt[{a,b}] is the gate output for that input pair
    int         n_tests;
    int         n_fail;

    xor_gate_sequencer_if intf ();

    xor_gate_sequencer #(.STEP_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    assign intf.dut_y = gate_tt[{intf.dut_a, intf.dut_b}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run from an accepted start edge, checked cycle by cycle.
    task automatic run_check(input logic [3:0] tt, input string name);
        logic [3:0] exp_res;
        logic [1:0] exp_fidx;
        bit         seen;
        int         n_vec;
        int         v;
        exp_res  = 4'd0;
        exp_fidx = 2'd0;
        seen     = 1'b0;
        n_vec    = 4;
        for (int i = 0; i < 4; i++) begin
            bit want;
            bit ok;
            want = ((i >> 1) & 1) != (i & 1);
            ok   = (tt[i] == want);
            if (i < n_vec) begin
                exp_res[i] = ok;
                if (!ok && !seen) begin
                    seen     = 1'b1;
                    exp_fidx = 2'(i);
`ifdef SEQ_STOP_ON_FAIL_EN
                    n_vec    = i + 1;
`endif
                end
            end
        end
        gate_tt = tt;
        intf.start = 1'b0;
        tick();
        intf.start = 1'b1;
        tick();
        intf.start = 1'b0;
        for (int t = 0; t < n_vec * S; t++) begin
            v = t / S;
            n_tests++;
            if (intf.busy !== 1'b1 || intf.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy/done t=%0d got %b/%b want 1/0", name, t, intf.busy, intf.done);
            end
            n_tests++;
            if ({intf.dut_a, intf.dut_b} !== 2'(v)) begin
                n_fail++;
                $display("FAIL %s vector t=%0d got %b%b want %0d", name, t, intf.dut_a, intf.dut_b, v);
            end
            tick();
        end
        n_tests++;
        if (intf.done !== 1'b1 || intf.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end done/busy got %b/%b want 1/0", name, intf.done, intf.busy);
        end
        n_tests++;
        if (intf.result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result got %b want %b", name, intf.result, exp_res);
        end
        n_tests++;
        if (intf.pass !== (exp_res == 4'b1111)) begin
            n_fail++;
            $display("FAIL %s pass got %b want %b", name, intf.pass, exp_res == 4'b1111);
        end
        n_tests++;
        if (intf.fail_idx !== exp_fidx) begin
            n_fail++;
            $display("FAIL %s fail_idx got %0d want %0d", name, intf.fail_idx, exp_fidx);
        end
        n_tests++;
        if ({intf.dut_a, intf.dut_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s done_drive got %b%b want 00", name, intf.dut_a, intf.dut_b);
        end
        tick();
        n_tests++;
        if (intf.done !== 1'b1 || intf.result !== exp_res || intf.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold got done=%b res=%b busy=%b want 1/%b/0", name, intf.done, intf.result, intf.busy, exp_res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        intf.start = 1'b0;
        gate_tt = 4'b0110;
        tick();
        tick();
        n_tests++;
        if ({intf.busy, intf.done, intf.pass, intf.result, intf.fail_idx, intf.dut_a, intf.dut_b} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0", {intf.busy, intf.done, intf.pass, intf.result, intf.fail_idx, intf.dut_a, intf.dut_b});
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({intf.busy, intf.done, intf.pass, intf.result, intf.fail_idx} !== 9'd0) begin
            n_fail++;
            $display("FAIL idle_outputs got %b want 0", {intf.busy, intf.done, intf.pass, intf.result, intf.fail_idx});
        end
    endtask

    task automatic test_patterns();
        run_check(4'b0110, "xor_ok");
        run_check(4'b0000, "stuck0");
        run_check(4'b1001, "xnor");
        run_check(4'b1111, "stuck1");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            run_check(4'($urandom_range(0, 15)), "random");
        end
    endtask

    task automatic test_start_held();
        int   rises;
        logic prev_done;
        rises = 0;
        prev_done = intf.done;
        gate_tt = 4'b0110;
        intf.start = 1'b0;
        tick();
        prev_done = intf.done;
        intf.start = 1'b1;
        tick();
        for (int t = 0; t < 40; t++) begin
            n_tests++;
            if (intf.busy !== (t < 4 * S) || intf.done !== (t >= 4 * S)) begin
                n_fail++;
                $display("FAIL held busy/done t=%0d got %b/%b want %b/%b", t, intf.busy, intf.done, t < 4 * S, t >= 4 * S);
            end
            if (intf.done === 1'b1 && prev_done !== 1'b1) rises++;
            prev_done = intf.done;
            if (t == 4 * S) begin
                n_tests++;
                if (intf.result !== 4'b1111 || intf.pass !== 1'b1) begin
                    n_fail++;
                    $display("FAIL held result got %b pass %b want 1111 1", intf.result, intf.pass);
                end
            end
            if (t == 4) intf.start = 1'b0;
            if (t == 5) intf.start = 1'b1;
            tick();
        end
        n_tests++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL held done_rises got %0d want 1", rises);
        end
        run_check(4'b0110, "after_held");
    endtask

    task automatic test_reset_mid_run();
        gate_tt = 4'b0110;
        intf.start = 1'b0;
        tick();
        intf.start = 1'b1;
        tick();
        for (int t = 0; t < 6; t++) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({intf.busy, intf.done, intf.pass, intf.result, intf.fail_idx, intf.dut_a, intf.dut_b} !== 11'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %b want 0", {intf.busy, intf.done, intf.pass, intf.result, intf.fail_idx, intf.dut_a, intf.dut_b});
        end
        intf.start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_tests++;
        if (intf.busy !== 1'b0 || intf.done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle got busy=%b done=%b want 0/0", intf.busy, intf.done);
        end
        run_check(4'b0110, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_check(4'b0110, "b2b_first");
        run_check(4'b0100, "b2b_second");
        run_check(4'b0110, "b2b_third");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        intf.start = 1'b0;
        gate_tt = 4'b0110;
        test_reset();
        test_patterns();
        test_random();
        test_start_held();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
